adpll_mod_ser: RTL and testbench

ADPLL_MOD_SER -- requirements
Module: adpll_mod_ser

---
 rtl/adpll_mod_ser_if.sv | 27 ++
 rtl/adpll_mod_ser.sv | 159 +++++++++++++++
 tb/tb_adpll_mod_ser.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adpll_mod_ser_if.sv
// CPU register-access bundle for adpll_mod_ser.
//   valid   : access request (master -> slave)
//   address : register select 0 MOD_EN, 1 MOD_DIV, 2 MOD_DATA, 3 MOD_STATUS
//   wdata   : write data
//   wstrb   : write enable, qualified by valid
//   rdata   : read data, combinational from address (slave -> master)
//   ready   : access acknowledge, one cycle after valid (slave -> master)
interface adpll_mod_ser_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [1:0]        address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/adpll_mod_ser.sv
// Serializer feeding the adpll_ctr data_mod input from CPU-written bytes.
// Bytes are queued in a small FIFO and shifted out LSB first, each bit held
// for div clock cycles (div = 0 behaves as 1). Consecutive queued bytes are
// sent back-to-back with no gap.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : CPU register access (slave side of adpll_mod_ser_if)
//   data_mod   : registered serial modulation bit
//   sym_strobe : one-cycle pulse on the first cycle of every transmitted bit
module adpll_mod_ser #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  adpll_mod_ser_if.slave  bus,
  output logic            data_mod,
  output logic            sym_strobe
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic               en;
  logic [DIV_W-1:0]   div, div_eff, divcnt, divcnt_n;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic [LVL_W-1:0]   level;
  logic [7:0]         level8;
  logic               ovf, udr;
  logic [7:0]         shreg, shreg_n, head;
  logic [2:0]         bitcnt, bitcnt_n;
  logic               data_mod_n, sym_strobe_n;
  logic               pop, udr_set;
  logic               wr, push, ovf_set, clr, empty, full, tc;
  logic               unused_wdata;

  assign wr      = bus.valid & bus.wstrb;
  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign head    = mem[rptr];
  assign div_eff = (div == '0) ? DIV_ONE : div;
  // >= rather than == so a smaller div written mid-bit cannot strand the counter
  assign tc      = (divcnt >= div_eff - DIV_ONE);
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign push    = wr && (bus.address == 2'd2) && (!full || pop);
  assign ovf_set = wr && (bus.address == 2'd2) && full && !pop;
  assign clr     = wr && (bus.address == 2'd3) && bus.wdata[0];
  assign level8  = 8'(level);
  assign unused_wdata = ^bus.wdata;

  always_comb begin
    bus.rdata = '1;
    if (bus.address == 2'd3)
      bus.rdata = DATA_W'({ovf, udr, state == SHIFT, full, empty, level8[2:0]});
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bitcnt_n     = bitcnt;
    divcnt_n     = divcnt;
    data_mod_n   = data_mod;
    sym_strobe_n = 1'b0;
    pop          = 1'b0;
    udr_set      = 1'b0;
    case (state)
      IDLE: begin
        data_mod_n = 1'b0;
        if (en && !empty) begin
          pop          = 1'b1;
          shreg_n      = head;
          data_mod_n   = head[0];
          bitcnt_n     = '0;
          divcnt_n     = '0;
          sym_strobe_n = 1'b1;
          state_n      = SHIFT;
        end
      end
      SHIFT: begin
        if (!tc) begin
          divcnt_n = divcnt + DIV_ONE;
        end else if (bitcnt != 3'd7) begin
          shreg_n      = {1'b0, shreg[7:1]};
          data_mod_n   = shreg[1];
          bitcnt_n     = bitcnt + 3'd1;
          divcnt_n     = '0;
          sym_strobe_n = 1'b1;
        end else if (en && !empty) begin
          pop          = 1'b1;
          shreg_n      = head;
          data_mod_n   = head[0];
          bitcnt_n     = '0;
          divcnt_n     = '0;
          sym_strobe_n = 1'b1;
        end else begin
          data_mod_n = 1'b0;
          udr_set    = en;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      divcnt     <= '0;
      data_mod   <= 1'b0;
      sym_strobe <= 1'b0;
      bus.ready  <= 1'b0;
      en         <= 1'b0;
      div        <= DIV_ONE;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      ovf        <= 1'b0;
      udr        <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      divcnt     <= divcnt_n;
      data_mod   <= data_mod_n;
      sym_strobe <= sym_strobe_n;
      bus.ready  <= bus.valid;
      if (wr && (bus.address == 2'd0)) en  <= bus.wdata[0];
      if (wr && (bus.address == 2'd1)) div <= bus.wdata[DIV_W-1:0];
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (ovf_set)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
      if (udr_set)  udr <= 1'b1;
      else if (clr) udr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wdata[7:0];
  end

endmodule

// File: tb/tb_adpll_mod_ser.sv
// Self-checking bench for adpll_mod_ser: directed scenarios with literal
// expectations, then randomized register traffic, all compared every cycle
// against a timeline-based behavioural model (byte start cycle + bit period).
module tb_adpll_mod_ser;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic data_mod, sym_strobe;

  adpll_mod_ser_if #(.DATA_W(32)) bus ();

  adpll_mod_ser #(.DATA_W(32), .DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .data_mod   (data_mod),
    .sym_strobe (sym_strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_q[$];
  logic [7:0]  m_cur    = '0;
  int unsigned m_e      = 0;
  int unsigned m_s      = 0;
  int unsigned m_div    = 1;
  bit          m_active = 0;
  bit          m_en     = 0;
  bit          m_ovf    = 0;
  bit          m_udr    = 0;
  bit          m_ready  = 0;
  bit          m_dm     = 0;
  bit          m_stb    = 0;

  function automatic logic [31:0] m_status();
    return 32'({m_ovf, m_udr, m_active, m_q.size() == DEPTH, m_q.size() == 0, 3'(m_q.size())});
  endfunction

  always @(posedge clk or negedge rst) begin
    int unsigned d, el;
    bit ovf_set, udr_set, clr;
    if (!rst) begin
      m_q.delete();
      m_cur = '0; m_e = 0; m_s = 0; m_div = 1; m_active = 0; m_en = 0;
      m_ovf = 0; m_udr = 0; m_ready = 0; m_dm = 0; m_stb = 0;
    end else begin
      ovf_set = 0; udr_set = 0; clr = 0;
      m_e++;
      d = (m_div == 0) ? 1 : m_div;
      // a byte occupies 8*d cycles starting at edge m_s
      if (m_active && (m_e - m_s) == 8 * d) begin
        if (m_en && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_s   = m_e;
        end else begin
          m_active = 0;
          udr_set  = m_en;
        end
      end else if (!m_active && m_en && m_q.size() > 0) begin
        m_cur    = m_q.pop_front();
        m_s      = m_e;
        m_active = 1;
      end
      if (m_active) begin
        el    = m_e - m_s;
        m_dm  = m_cur[el / d];
        m_stb = (el % d) == 0;
      end else begin
        m_dm  = 0;
        m_stb = 0;
      end
      if (bus.valid && bus.wstrb) begin
        case (bus.address)
          2'd0: m_en  = bus.wdata[0];
          2'd1: m_div = int'(bus.wdata[15:0]);
          2'd2: if (m_q.size() < DEPTH) m_q.push_back(bus.wdata[7:0]);
                else ovf_set = 1;
          default: clr = bus.wdata[0];
        endcase
      end
      if (clr) begin m_ovf = 0; m_udr = 0; end
      if (ovf_set) m_ovf = 1;
      if (udr_set) m_udr = 1;
      m_ready = bus.valid;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    check("data_mod", 32'(data_mod), 32'(m_dm));
    check("sym_strobe", 32'(sym_strobe), 32'(m_stb));
    check("ready", 32'(bus.ready), 32'(m_ready));
    exp_rd = (bus.address == 2'd3) ? m_status() : 32'hFFFF_FFFF;
    check("rdata", bus.rdata, exp_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    bus.valid = 1'b1; bus.wstrb = 1'b1; bus.address = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.wstrb = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = a;
    @(negedge clk);
    d = bus.rdata;
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, tr, st;
    bus.valid = 1'b0; bus.wstrb = 1'b0; bus.address = 2'd0; bus.wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.address = 2'd3;
    #1;
    check("reset_status", bus.rdata, 32'h08);
    check("reset_data_mod", 32'(data_mod), 32'h0);
    check("reset_ready", 32'(bus.ready), 32'h0);
    check("reset_strobe", 32'(sym_strobe), 32'h0);
    bus.address = 2'd0;
    #1 check("rdata_other_addr", bus.rdata, 32'hFFFF_FFFF);
    @(posedge clk); #1 rst = 1'b1;

    // div = 4, single byte 0xA5, then underrun
    cpu_write(2'd1, 32'd4);
    cpu_write(2'd0, 32'd1);
    cpu_write(2'd2, 32'hA5);
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      tr[i] = data_mod; st[i] = sym_strobe;
    end
    check("a5_bits", tr, 32'hF0F0_0F0F);
    check("a5_strobes", st, 32'h1111_1111);
    @(posedge clk); #1;
    cpu_read(2'd3, rd);
    check("a5_end_status", rd, 32'h48);
    cpu_write(2'd3, 32'd1);

    // overflow with en = 0
    cpu_write(2'd0, 32'd0);
    for (int i = 1; i <= 5; i++) cpu_write(2'd2, 32'(8'h11 * i));
    cpu_read(2'd3, rd);
    check("ovf_status", rd, 32'h94);
    cpu_write(2'd3, 32'd1);
    cpu_read(2'd3, rd);
    check("ovf_cleared", rd, 32'h14);

    // div = 0, push while full alongside an idle pop and a bit-7 pop
    cpu_write(2'd1, 32'd0);
    cpu_write(2'd0, 32'd1);
    cpu_write(2'd2, 32'h66);
    idle(7);
    cpu_write(2'd2, 32'h77);
    // sampled one cycle after the bit-7 pop/push edge
    bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = 2'd3;
    @(negedge clk);
    check("full_pop_push_status", bus.rdata, 32'h34);
    @(posedge clk); #1 bus.valid = 1'b0;
    idle(60);
    cpu_read(2'd3, rd);
    check("div0_drain_status", rd, 32'h48);
    cpu_write(2'd3, 32'd1);

    // div = 2, 0xFF then 0x00 back-to-back
    cpu_write(2'd1, 32'd2);
    cpu_write(2'd2, 32'hFF);
    cpu_write(2'd2, 32'h00);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      tr[i] = data_mod; st[i] = sym_strobe;
    end
    check("b2b_bits", tr, 32'h0000_FFFF);
    check("b2b_strobes", st, 32'h5555_5555);
    @(posedge clk); #1;
    cpu_read(2'd3, rd);
    check("b2b_end_status", rd, 32'h48);
    cpu_write(2'd3, 32'd1);

    // en cleared during bit 3 of 0x0F with a second byte queued
    cpu_write(2'd1, 32'd4);
    cpu_write(2'd2, 32'h0F);
    cpu_write(2'd2, 32'hAA);
    idle(12);
    cpu_write(2'd0, 32'd0);
    idle(19);
    cpu_read(2'd3, rd);
    check("en_off_status", rd, 32'h01);
    check("en_off_data_mod", 32'(data_mod), 32'h0);
    cpu_write(2'd0, 32'd1);
    idle(50);
    cpu_read(2'd3, rd);
    check("en_on_drain_status", rd, 32'h48);
    cpu_write(2'd3, 32'd1);

    // asynchronous reset during SHIFT
    cpu_write(2'd2, 32'hFF);
    cpu_write(2'd2, 32'h3C);
    idle(5);
    bus.valid = 1'b1; bus.wstrb = 1'b0; bus.address = 2'd3;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_data_mod", 32'(data_mod), 32'h0);
    check("async_rst_ready", 32'(bus.ready), 32'h0);
    check("async_rst_strobe", 32'(sym_strobe), 32'h0);
    check("async_rst_status", bus.rdata, 32'h08);
    @(posedge clk); #1 rst = 1'b1; bus.valid = 1'b0;
    cpu_write(2'd2, 32'h81);
    idle(20);
    cpu_read(2'd3, rd);
    check("post_rst_en_off", rd, 32'h01);
    check("post_rst_data_mod", 32'(data_mod), 32'h0);

    // randomized traffic
    for (int it = 0; it < 600; it++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: idle(int'($urandom_range(1, 3)));
        4, 5: cpu_write(2'd2, 32'($urandom_range(0, 255)));
        6: cpu_write(2'd0, 32'($urandom_range(0, 3) != 0));
        7: if (!m_active && !(m_en && m_q.size() > 0))
             cpu_write(2'd1, 32'($urandom_range(0, 3)));
           else
             idle(1);
        8: cpu_write(2'd3, 32'($urandom_range(0, 1)));
        default: cpu_read(2'($urandom_range(0, 3)), rd);
      endcase
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
